// File: rtl/seg7_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg7_display_arbiter
//
// Shares a single 7-segment display between three requesters. A round-robin
// arbiter hands the display to one requester at a time. The owner keeps it
// until it drops its request, or until it has held it for HOLD_TICKS cycles
// while someone else is waiting. Every change of owner is separated by
// BLANK_TICKS cycles of dark display, so one owner's pattern never flashes
// into the next owner's pattern.
//
// Parameters
//   HOLD_TICKS   minimum grant time in clk_i cycles before forced rotation (>= 2)
//   BLANK_TICKS  all-off cycles between owners (>= 1)
//
// Ports
//   clk_i      sole clock, rising edge
//   rst_ni     synchronous active-low reset
//   req_i      per-requester display request, level-sensitive
//   seg0_i..   segment pattern of requester 0/1/2 (bit0 = segment a)
//   gnt_o      registered one-hot grant, zero when nobody owns the display
//   owner_o    index of the current or most recent owner
//   busy_o     high while granting or blanking
//   seg_o      registered segment drive, lags gnt_o by one cycle
// -----------------------------------------------------------------------------
module seg7_display_arbiter #(
   parameter int unsigned HOLD_TICKS  = 20_000_000,
   parameter int unsigned BLANK_TICKS = 2_500_000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [2:0] req_i,
   input  logic [6:0] seg0_i,
   input  logic [6:0] seg1_i,
   input  logic [6:0] seg2_i,
   output logic [2:0] gnt_o,
   output logic [1:0] owner_o,
   output logic       busy_o,
   output logic [6:0] seg_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_BLANK
   } state_e;

   localparam logic [31:0] HOLD_MAX  = 32'(HOLD_TICKS - 1);
   localparam logic [31:0] BLANK_MAX = 32'(BLANK_TICKS - 1);

   state_e      state_q;
   logic [2:0]  gnt_q;
   logic [1:0]  owner_q;
   logic [6:0]  seg_q;
   logic [31:0] hold_cnt_q;
   logic [31:0] hold_cnt_d;
   logic [31:0] blank_cnt_q;
   logic [31:0] blank_cnt_d;

   logic [3:0]  req_pad;
   logic [1:0]  cand1;
   logic [1:0]  cand2;
   logic [1:0]  winner;
   logic [2:0]  winner_gnt;
   logic        any_req;
   logic        own_req;
   logic        other_req;
   logic [6:0]  seg_sel;

   // Next index in the 0 -> 1 -> 2 -> 0 rotation.
   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   // Padding to four bits lets a 2-bit index select without a range hazard.
   assign req_pad = {1'b0, req_i};
   assign any_req = |req_i;

   // While granted, gnt_q is the owner's one-hot mask.
   assign own_req   = |(req_i & gnt_q);
   assign other_req = |(req_i & ~gnt_q);

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      cand1  = rr_next(owner_q);
      cand2  = rr_next(cand1);
      winner = owner_q;
      if (req_pad[cand1]) begin
         winner = cand1;
      end else if (req_pad[cand2]) begin
         winner = cand2;
      end
      winner_gnt = 3'b001 << winner;
   end

   always_comb begin
      seg_sel = seg2_i;
      case (owner_q)
         2'd0:    seg_sel = seg0_i;
         2'd1:    seg_sel = seg1_i;
         default: seg_sel = seg2_i;
      endcase
   end

   // Hold counter saturates so a lone owner can keep the display indefinitely.
   assign hold_cnt_d  = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 32'd1;
   assign blank_cnt_d = blank_cnt_q + 32'd1;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      // NOTE: reset is sampled on the clock edge; it wins over any state.
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         owner_q     <= 2'd2;
         seg_q       <= '0;
         hold_cnt_q  <= '0;
         blank_cnt_q <= '0;
      end else begin
         // Drive the owner's live pattern only while granted.
         seg_q <= (state_q == ST_GRANT) ? seg_sel : '0;

         case (state_q)
            ST_IDLE: begin
               if (any_req) begin
                  state_q    <= ST_GRANT;
                  gnt_q      <= winner_gnt;
                  owner_q    <= winner;
                  hold_cnt_q <= '0;
               end
            end

            ST_GRANT: begin
               // Voluntary release and forced rotation share one exit.
               if (!own_req || ((hold_cnt_q == HOLD_MAX) && other_req)) begin
                  state_q     <= ST_BLANK;
                  gnt_q       <= '0;
                  blank_cnt_q <= '0;
               end else begin
                  hold_cnt_q <= hold_cnt_d;
               end
            end

            ST_BLANK: begin
               // Requests arriving here are not remembered.
               if (blank_cnt_q == BLANK_MAX) begin
                  state_q <= ST_IDLE;
               end else begin
                  blank_cnt_q <= blank_cnt_d;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end

   assign gnt_o   = gnt_q;
   assign owner_o = owner_q;
   assign busy_o  = (state_q != ST_IDLE);
   assign seg_o   = seg_q;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seg7_display_arbiter
//
// Directed bench for seg7_display_arbiter with HOLD_TICKS=4, BLANK_TICKS=2.
// Inputs change and outputs are sampled on the falling edge, half a cycle
// away from the rising edge where the design updates.
// -----------------------------------------------------------------------------
module tb_seg7_display_arbiter;

   logic       clk;
   logic       rst_ni;
   logic [2:0] req_i;
   logic [6:0] seg0_i;
   logic [6:0] seg1_i;
   logic [6:0] seg2_i;
   logic [2:0] gnt_o;
   logic [1:0] owner_o;
   logic       busy_o;
   logic [6:0] seg_o;

   int total;
   int bad;

   seg7_display_arbiter #(
      .HOLD_TICKS (4),
      .BLANK_TICKS(2)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .req_i  (req_i),
      .seg0_i (seg0_i),
      .seg1_i (seg1_i),
      .seg2_i (seg2_i),
      .gnt_o  (gnt_o),
      .owner_o(owner_o),
      .busy_o (busy_o),
      .seg_o  (seg_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, ending on a falling edge.
   task automatic adv(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all(input string tag, input logic [2:0] g, input logic [1:0] o,
                            input logic b, input logic [6:0] s);
      check({tag, ".gnt"},   32'(gnt_o),   32'(g));
      check({tag, ".owner"}, 32'(owner_o), 32'(o));
      check({tag, ".busy"},  32'(busy_o),  32'(b));
      check({tag, ".seg"},   32'(seg_o),   32'(s));
   endtask

   initial begin
      logic [6:0] v;
      total  = 0;
      bad    = 0;
      rst_ni = 1'b0;
      req_i  = 3'b000;
      seg0_i = 7'h3F;
      seg1_i = 7'h06;
      seg2_i = 7'h5B;

      // Reset state.
      adv(2);
      check_all("reset", 3'b000, 2'd2, 1'b0, 7'h00);

      // All three request: requester 0 wins first, four grant cycles,
      // two blank cycles, one idle cycle, then requester 1.
      rst_ni = 1'b1;
      req_i  = 3'b111;
      adv(1);
      check_all("rr.g1", 3'b001, 2'd0, 1'b1, 7'h00);
      adv(1);
      check_all("rr.g2", 3'b001, 2'd0, 1'b1, 7'h3F);
      seg0_i = 7'h4F;                       // live pass-through while granted
      adv(1);
      check_all("rr.g3", 3'b001, 2'd0, 1'b1, 7'h4F);
      adv(1);
      check_all("rr.g4", 3'b001, 2'd0, 1'b1, 7'h4F);
      adv(1);
      check_all("rr.b1", 3'b000, 2'd0, 1'b1, 7'h4F);
      adv(1);
      check_all("rr.b2", 3'b000, 2'd0, 1'b1, 7'h00);
      adv(1);
      check_all("rr.idle", 3'b000, 2'd0, 1'b0, 7'h00);
      adv(1);
      check_all("rr.next", 3'b010, 2'd1, 1'b1, 7'h00);

      // Owner 1 releases at once; requester 1 pulses only during blank.
      req_i = 3'b000;
      adv(1);
      check_all("rel.b1", 3'b000, 2'd1, 1'b1, 7'h06);
      req_i = 3'b010;
      adv(1);
      check_all("rel.b2", 3'b000, 2'd1, 1'b1, 7'h00);
      req_i = 3'b000;
      adv(1);
      check_all("rel.idle", 3'b000, 2'd1, 1'b0, 7'h00);
      adv(1);
      check_all("blankreq.ignored", 3'b000, 2'd1, 1'b0, 7'h00);

      // Lone requester 2 keeps the display past saturation; seg tracks live.
      req_i = 3'b100;
      adv(1);
      check_all("solo.g", 3'b100, 2'd2, 1'b1, 7'h00);
      for (int i = 0; i < 20; i++) begin
         v      = 7'((i * 13 + 5) & 7'h7F);
         seg2_i = v;
         adv(1);
         check("solo.gnt", 32'(gnt_o), 32'(3'b100));
         check("solo.busy", 32'(busy_o), 32'(1'b1));
         check("solo.seg", 32'(seg_o), 32'(v));
      end

      // Others arrive: saturated owner is rotated out immediately.
      seg2_i = 7'h5B;
      req_i  = 3'b111;
      adv(1);
      check_all("force.b1", 3'b000, 2'd2, 1'b1, 7'h5B);
      adv(1);
      check_all("force.b2", 3'b000, 2'd2, 1'b1, 7'h00);
      adv(1);
      check_all("force.idle", 3'b000, 2'd2, 1'b0, 7'h00);
      adv(1);
      check_all("force.g1", 3'b001, 2'd0, 1'b1, 7'h00);

      // Owner 0 drops its request on grant cycle 2.
      adv(1);
      check_all("drop.g2", 3'b001, 2'd0, 1'b1, 7'h4F);
      req_i = 3'b110;
      adv(1);
      check_all("drop.b1", 3'b000, 2'd0, 1'b1, 7'h4F);
      adv(1);
      check_all("drop.b2", 3'b000, 2'd0, 1'b1, 7'h00);
      adv(1);
      check_all("drop.idle", 3'b000, 2'd0, 1'b0, 7'h00);
      adv(1);
      check_all("drop.next", 3'b010, 2'd1, 1'b1, 7'h00);

      // Reset for one cycle in the middle of a grant.
      seg1_i = 7'h7F;
      req_i  = 3'b111;
      adv(1);
      check_all("mid.g2", 3'b010, 2'd1, 1'b1, 7'h7F);
      rst_ni = 1'b0;
      adv(1);
      check_all("mid.reset", 3'b000, 2'd2, 1'b0, 7'h00);
      rst_ni = 1'b1;
      adv(1);
      check_all("mid.regrant", 3'b001, 2'd0, 1'b1, 7'h00);

      // Release coinciding with hold expiry: a single pass through blank.
      adv(3);
      check_all("both.g4", 3'b001, 2'd0, 1'b1, 7'h4F);
      req_i = 3'b110;
      adv(1);
      check_all("both.b1", 3'b000, 2'd0, 1'b1, 7'h4F);
      adv(1);
      check_all("both.b2", 3'b000, 2'd0, 1'b1, 7'h00);
      adv(1);
      check_all("both.idle", 3'b000, 2'd0, 1'b0, 7'h00);
      adv(1);
      check_all("both.next", 3'b010, 2'd1, 1'b1, 7'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
